// File: rtl/mp3_ctrl.sv
// User-control front end: debounced buttons, song/pause levels and a saturating
// volume level posted to the VS1003 driver as SCI_VOL words. Optional: MP3_CTRL_AUTOREPEAT_EN.
module mp3_ctrl #(
  parameter int          DEBOUNCE_CYC = 20000,
  parameter logic [7:0]  VOL_INIT     = 8'h20,
  parameter logic [7:0]  VOL_STEP     = 8'h10,
  parameter int          REPEAT_CYC   = 2000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_btn_next,
  input  logic        i_btn_pause,
  input  logic        i_btn_up,
  input  logic        i_btn_down,
  input  logic        i_ack,
  output logic        o_song_select,
  output logic        o_pause,
  output logic [15:0] o_vol,
  output logic [7:0]  o_level
);

  localparam int            CW       = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  // Button bit order: 0 next, 1 pause, 2 up, 3 down.
  logic [3:0] btn_raw, btn_s1, btn_s2, deb, deb_d, rise;
  logic       ev_next, ev_pause, ev_up, ev_down;

  assign btn_raw = {i_btn_down, i_btn_up, i_btn_pause, i_btn_next};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      deb_d  <= '0;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
      deb_d  <= deb;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_deb
    logic [CW-1:0] cnt;
    logic          db;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
        db  <= 1'b0;
      end else if (btn_s2[i] == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt <= '0;
        db  <= ~db;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
    assign deb[i] = db;
  end

  assign rise     = deb & ~deb_d;
  assign ev_next  = rise[0];
  assign ev_pause = rise[1];

`ifdef MP3_CTRL_AUTOREPEAT_EN
  localparam int            RW       = $clog2(REPEAT_CYC + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYC);
  logic [1:0] rep_tick;

  // Counts cycles since the initial edge; reloads to 1 so ticks stay REPEAT_CYC apart.
  for (genvar j = 0; j < 2; j++) begin : g_rep
    logic [RW-1:0] rcnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                rcnt <= '0;
      else if (!deb[j+2])        rcnt <= '0;
      else if (rcnt == REP_LAST) rcnt <= RW'(1);
      else                       rcnt <= rcnt + 1'b1;
    end
    assign rep_tick[j] = deb[j+2] & (rcnt == REP_LAST);
  end

  assign ev_up   = rise[2] | rep_tick[0];
  assign ev_down = rise[3] | rep_tick[1];
`else
  if (REPEAT_CYC < 0) begin : g_repeat_unused
  end
  assign ev_up   = rise[2];
  assign ev_down = rise[3];
`endif

  logic [7:0] lvl, lvl_inc, lvl_dec, vlat;
  logic [8:0] sum9;
  logic       lvl_evt;

  assign sum9    = {1'b0, lvl} + {1'b0, VOL_STEP};
  assign lvl_inc = (sum9 > 9'h0FE) ? 8'hFE : sum9[7:0];
  assign lvl_dec = (lvl < VOL_STEP) ? 8'h00 : lvl - VOL_STEP;
  assign lvl_evt = ev_up ^ ev_down;
  assign o_level = lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl           <= VOL_INIT;
      o_song_select <= 1'b0;
      o_pause       <= 1'b0;
    end else begin
      if (ev_next)               o_song_select <= ~o_song_select;
      if (ev_pause)              o_pause       <= ~o_pause;
      if (ev_up && !ev_down)     lvl           <= lvl_dec;
      else if (ev_down && !ev_up) lvl          <= lvl_inc;
    end
  end

  logic [2:0] ack_s;
  logic       ack_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_s <= '0;
    else        ack_s <= {ack_s[1:0], i_ack};
  end

  // Edge only: the driver holds finish high while paused.
  assign ack_rise = ack_s[1] & ~ack_s[2];

  typedef enum logic [1:0] {IDLE, POST, GAP} state_t;
  state_t     state, next_state;
  logic       pend, latch, pause_next, pause_rise;
  logic [1:0] gap_cnt;

  assign pause_next = o_pause ^ ev_pause;
  assign pause_rise = ev_pause & ~o_pause;
  assign latch      = (state == IDLE) && (next_state == POST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pend && !pause_next) next_state = POST;
      POST:    if (pause_rise)          next_state = IDLE;
               else if (ack_rise)       next_state = GAP;
      GAP:     if (gap_cnt == 2'd3)     next_state = IDLE;
      default:                          next_state = IDLE;
    endcase
  end

  always_comb begin
    o_vol = 16'hFFFF;
    if (state == POST) o_vol = {vlat, vlat};
  end

  // A new change always wins over the clear, so a change on the latch cycle is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= 1'b1;
      vlat    <= VOL_INIT;
      gap_cnt <= 2'd0;
    end else begin
      if (lvl_evt || ev_next || (state == POST && pause_rise)) pend <= 1'b1;
      else if (latch)                                          pend <= 1'b0;
      if (latch) vlat <= lvl;
      gap_cnt <= (state == GAP) ? gap_cnt + 2'd1 : 2'd0;
    end
  end

endmodule

// File: tb/tb_mp3_ctrl.sv
// Bench for mp3_ctrl: directed scenarios plus a random button/ack sequence
// checked against a behavioural model of levels and outstanding requests.
module tb_mp3_ctrl;

  localparam int REP = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_btn_next = 1'b0, i_btn_pause = 1'b0, i_btn_up = 1'b0, i_btn_down = 1'b0;
  logic        i_ack = 1'b0;
  logic        o_song_select, o_pause;
  logic [15:0] o_vol;
  logic [7:0]  o_level;

  int n_checks = 0;
  int n_fail   = 0;

  mp3_ctrl #(
    .DEBOUNCE_CYC(4), .VOL_INIT(8'h20), .VOL_STEP(8'h10), .REPEAT_CYC(REP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_btn_next(i_btn_next), .i_btn_pause(i_btn_pause),
    .i_btn_up(i_btn_up), .i_btn_down(i_btn_down),
    .i_ack(i_ack),
    .o_song_select(o_song_select), .o_pause(o_pause),
    .o_vol(o_vol), .o_level(o_level)
  );

  always #5 clk = ~clk;

  // Model: level, toggles, a pending flag and the outstanding request word (exp_q).
  int          m_lvl;
  logic        m_pause, m_song, m_pend;
  logic [15:0] exp_q[$];

  function automatic logic [15:0] m_vol();
    return (exp_q.size() != 0) ? exp_q[0] : 16'hFFFF;
  endfunction

  task automatic m_try_post();
    if (exp_q.size() == 0 && m_pend && !m_pause) begin
      exp_q.push_back({m_lvl[7:0], m_lvl[7:0]});
      m_pend = 1'b0;
    end
  endtask

  task automatic m_reset();
    m_lvl = 32; m_pause = 1'b0; m_song = 1'b0; m_pend = 1'b1;
    exp_q.delete();
  endtask

  task automatic m_level(input logic up);
    if (up) m_lvl = (m_lvl < 16) ? 0 : m_lvl - 16;
    else    m_lvl = (m_lvl + 16 > 254) ? 254 : m_lvl + 16;
    m_pend = 1'b1;
    m_try_post();
  endtask

  task automatic m_ack();
    if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      m_try_post();
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mask bits: 0 next, 1 pause, 2 up, 3 down
  task automatic press(input logic [3:0] mask);
    {i_btn_down, i_btn_up, i_btn_pause, i_btn_next} = mask;
    cycles(12);
    {i_btn_down, i_btn_up, i_btn_pause, i_btn_next} = 4'b0000;
    cycles(12);
    if (mask[0]) begin m_song = ~m_song; m_pend = 1'b1; m_try_post(); end
    if (mask[1]) begin
      if (!m_pause && exp_q.size() != 0) begin void'(exp_q.pop_front()); m_pend = 1'b1; end
      m_pause = ~m_pause;
      m_try_post();
    end
    if (mask[2] != mask[3]) m_level(mask[2]);
  endtask

  task automatic ack_pulse();
    i_ack = 1'b1;
    cycles(3);
    i_ack = 1'b0;
    cycles(10);
    m_ack();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_reset();
    cycles(3);
    n_checks++;
    if (o_vol !== 16'hFFFF) begin n_fail++; $display("FAIL reset_vol: got %h want ffff", o_vol); end
    n_checks++;
    if (o_level !== 8'h20) begin n_fail++; $display("FAIL reset_level: got %h want 20", o_level); end
    n_checks++;
    if ({o_song_select, o_pause} !== 2'b00) begin
      n_fail++; $display("FAIL reset_song_pause: got %b want 00", {o_song_select, o_pause});
    end
    rst_n = 1'b1;
    m_try_post();
    cycles(2);
    n_checks++;
    if (o_vol !== 16'h2020) begin n_fail++; $display("FAIL initial_post: got %h want 2020", o_vol); end
    i_ack = 1'b1;
    cycles(2);
    n_checks++;
    if (o_vol !== 16'h2020) begin n_fail++; $display("FAIL ack_early: got %h want 2020", o_vol); end
    cycles(1);
    n_checks++;
    if (o_vol !== 16'hFFFF) begin n_fail++; $display("FAIL ack_latency: got %h want ffff", o_vol); end
    i_ack = 1'b0;
    cycles(10);
    m_ack();
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 10; i++) begin
      i_btn_down = ~i_btn_down;
      cycles(2);
    end
    i_btn_down = 1'b0;
    cycles(10);
    n_checks++;
    if (o_level !== 8'h20) begin n_fail++; $display("FAIL bounce_level: got %h want 20", o_level); end
    n_checks++;
    if (o_vol !== 16'hFFFF) begin n_fail++; $display("FAIL bounce_vol: got %h want ffff", o_vol); end
    press(4'b1000);
    n_checks++;
    if (o_level !== 8'h30) begin n_fail++; $display("FAIL held_level: got %h want 30", o_level); end
    n_checks++;
    if (o_vol !== 16'h3030) begin n_fail++; $display("FAIL held_vol: got %h want 3030", o_vol); end
    ack_pulse();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      press(4'b0100);
      n_checks++;
      if (o_vol !== m_vol()) begin n_fail++; $display("FAIL up_vol[%0d]: got %h want %h", i, o_vol, m_vol()); end
      ack_pulse();
    end
    n_checks++;
    if (o_level !== 8'h00) begin n_fail++; $display("FAIL up_floor: got %h want 00", o_level); end
    for (int i = 0; i < 20; i++) begin
      if (i != 0) ack_pulse();
      press(4'b1000);
      n_checks++;
      if (o_level !== m_lvl[7:0]) begin n_fail++; $display("FAIL down_level[%0d]: got %h want %h", i, o_level, m_lvl[7:0]); end
      n_checks++;
      if (o_vol !== m_vol() || o_vol === 16'hFFFF) begin
        n_fail++; $display("FAIL down_vol[%0d]: got %h want %h", i, o_vol, m_vol());
      end
    end
    n_checks++;
    if (o_vol !== 16'hFEFE) begin n_fail++; $display("FAIL ceiling_vol: got %h want fefe", o_vol); end
    n_checks++;
    if (o_level !== 8'hFE) begin n_fail++; $display("FAIL ceiling_level: got %h want fe", o_level); end
    // Asynchronous reset while a request is posted.
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_vol !== 16'hFFFF || o_level !== 8'h20) begin
      n_fail++; $display("FAIL async_reset: got vol %h level %h want ffff 20", o_vol, o_level);
    end
    m_reset();
    cycles(2);
    rst_n = 1'b1;
    m_try_post();
    cycles(2);
    n_checks++;
    if (o_vol !== 16'h2020) begin n_fail++; $display("FAIL repost_after_reset: got %h want 2020", o_vol); end
    ack_pulse();
  endtask

  task automatic test_pause();
    press(4'b0010);
    press(4'b1000);
    n_checks++;
    if (o_pause !== 1'b1 || o_vol !== 16'hFFFF) begin
      n_fail++; $display("FAIL pause_defer: got pause %b vol %h want 1 ffff", o_pause, o_vol);
    end
    i_ack = 1'b1;
    cycles(10);
    m_ack();
    press(4'b0010);
    n_checks++;
    if (o_pause !== 1'b0 || o_vol !== 16'h3030) begin
      n_fail++; $display("FAIL unpause_post: got pause %b vol %h want 0 3030", o_pause, o_vol);
    end
    i_ack = 1'b0;
    cycles(4);
    n_checks++;
    if (o_vol !== 16'h3030) begin n_fail++; $display("FAIL level_ack_held: got %h want 3030", o_vol); end
    ack_pulse();
    press(4'b1000);
    press(4'b0010);
    n_checks++;
    if (o_vol !== 16'hFFFF) begin n_fail++; $display("FAIL pause_cancels_post: got %h want ffff", o_vol); end
    press(4'b0010);
    n_checks++;
    if (o_vol !== 16'h4040) begin n_fail++; $display("FAIL cancel_repost: got %h want 4040", o_vol); end
    ack_pulse();
  endtask

  task automatic test_song();
    press(4'b0001);
    n_checks++;
    if (o_song_select !== 1'b1 || o_vol !== 16'h4040) begin
      n_fail++; $display("FAIL song_repost: got song %b vol %h want 1 4040", o_song_select, o_vol);
    end
    ack_pulse();
    press(4'b1100);
    n_checks++;
    if (o_level !== 8'h40 || o_vol !== 16'hFFFF) begin
      n_fail++; $display("FAIL up_down_same_cycle: got level %h vol %h want 40 ffff", o_level, o_vol);
    end
    press(4'b1000);
    press(4'b0001);
    n_checks++;
    if (o_vol !== 16'h5050 || o_song_select !== 1'b0) begin
      n_fail++; $display("FAIL next_in_post: got vol %h song %b want 5050 0", o_vol, o_song_select);
    end
    ack_pulse();
    n_checks++;
    if (o_vol !== 16'h5050) begin n_fail++; $display("FAIL next_repost: got %h want 5050", o_vol); end
    ack_pulse();
  endtask

  task automatic test_autorepeat();
    int events;
`ifdef MP3_CTRL_AUTOREPEAT_EN
    events = 4;
`else
    events = 1;
`endif
    i_btn_up = 1'b1;
    cycles(160);
    i_btn_up = 1'b0;
    cycles(12);
    for (int i = 0; i < events; i++) m_level(1'b1);
    n_checks++;
    if (o_level !== m_lvl[7:0]) begin n_fail++; $display("FAIL repeat_level: got %h want %h", o_level, m_lvl[7:0]); end
    n_checks++;
    if (o_vol !== m_vol()) begin n_fail++; $display("FAIL repeat_vol: got %h want %h", o_vol, m_vol()); end
    ack_pulse();
    n_checks++;
    if (o_vol !== m_vol()) begin n_fail++; $display("FAIL repeat_after_ack: got %h want %h", o_vol, m_vol()); end
    ack_pulse();
  endtask

  task automatic test_random();
    logic [3:0] masks [5];
    masks[0] = 4'b0001; masks[1] = 4'b0010; masks[2] = 4'b0100;
    masks[3] = 4'b1000; masks[4] = 4'b1100;
    for (int i = 0; i < 40; i++) begin
      int op;
      op = $urandom_range(0, 7);
      if (op >= 5) ack_pulse();
      else         press(masks[op]);
      n_checks++;
      if (o_level !== m_lvl[7:0]) begin n_fail++; $display("FAIL rnd_level[%0d]: got %h want %h", i, o_level, m_lvl[7:0]); end
      n_checks++;
      if (o_vol !== m_vol()) begin n_fail++; $display("FAIL rnd_vol[%0d]: got %h want %h", i, o_vol, m_vol()); end
      n_checks++;
      if ({o_song_select, o_pause} !== {m_song, m_pause}) begin
        n_fail++; $display("FAIL rnd_song_pause[%0d]: got %b want %b", i, {o_song_select, o_pause}, {m_song, m_pause});
      end
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_saturation();
    test_pause();
    test_song();
    test_autorepeat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mp3_ctrl.md
# mp3_ctrl

User-control front end for the MP3 player, directly upstream of the VS1003 SPI driver. It debounces four raw push-buttons (next song, pause, volume up, volume down) and maintains the song-select and pause levels. It also holds a saturating volume attenuation level and posts volume-change requests to the driver. A request is presented as a 16-bit VS1003 SCI_VOL word and held until the driver acknowledges it through its finish strobe.

## Interface
- `DEBOUNCE_CYC`, 20000: clk cycles a synchronised button must be stable before its debounced level changes.
- `VOL_INIT`, 8'h20: attenuation level after reset.
- `VOL_STEP`, 8'h10: attenuation change per volume press.
- `REPEAT_CYC`, 2000000: auto-repeat period in clk cycles; used only with `MP3_CTRL_AUTOREPEAT_EN`.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_btn_next` in 1: raw button, active-high, asynchronous.
- `i_btn_pause` in 1: raw button, active-high, asynchronous.
- `i_btn_up` in 1: raw button, active-high, asynchronous; louder.
- `i_btn_down` in 1: raw button, active-high, asynchronous; quieter.
- `i_ack` in 1: driver finish strobe, asynchronous to clk.
- `o_song_select` out 1: song index level to the driver.
- `o_pause` out 1: pause level to the driver.
- `o_vol` out 16: volume request word. 16'hFFFF means no request.
- `o_level` out 8: current attenuation, for display.

## Operation
- **Button conditioning.** Each button passes through a 2-flop synchroniser, then a per-button stability counter. The debounced level updates once the synchronised input has differed from it for `DEBOUNCE_CYC` consecutive cycles; any bounce restarts the counter. A press event is a 0→1 edge of the debounced level.
- **Next press.** Toggles `o_song_select`. It also sets `pend`, because a song change resets the driver's volume to 0x0000.
- **Pause press.** Toggles `o_pause`.
- **Volume up.** `lvl = (lvl < VOL_STEP) ? 0 : lvl - VOL_STEP`. Sets `pend`.
- **Volume down.** `lvl = min(lvl + VOL_STEP, 8'hFE)`, computed 9-bit internally. Sets `pend`.
- **Level limits.**
  - `lvl` never equals 8'hFF, which keeps 16'hFFFF reserved as the no-request sentinel.
  - An up or down press that saturates still sets `pend`.
- **Simultaneous up and down events** in the same cycle: both are ignored and `pend` is unchanged.
- **Acknowledge detection.** `i_ack` is 2-flop synchronised; `ack_rise` is the 0→1 edge of the synchronised signal. A level-high ack is never treated as an acknowledge, because the driver holds finish high continuously while paused.
- **Request FSM, state IDLE.** `o_vol` = 16'hFFFF. If `pend` is set and `o_pause` is 0: latch `vlat = lvl`, clear `pend`, go to POST.
- **Request FSM, state POST.** `o_vol` = {`vlat`, `vlat`}, same attenuation on both channels.
  - On `ack_rise`, go to GAP.
  - If `o_pause` rises while in POST, go to IDLE and set `pend`.
- **Request FSM, state GAP.** `o_vol` = 16'hFFFF for 4 cycles, then go to IDLE. This guarantees the driver observes the sentinel between requests.
- **Level changes during POST or GAP.** These only set `pend`; `vlat` is not updated. A fresh request follows after GAP.
- **Next press during POST.** Sets `pend`; the FSM stays in POST. The driver's reset pulse on finish acts as the ack, and the re-post follows.

## Timing
- **Reset values.**
  - Outputs: `o_song_select`=0, `o_pause`=0, `o_vol`=16'hFFFF, `o_level`=`VOL_INIT`.
  - Internal: FSM in IDLE, `pend`=1 so the initial volume is applied, all debounce counters 0, debounced levels 0.
- **Press latency.** A raw edge held stable reaches its debounced level change after 2 + `DEBOUNCE_CYC` cycles. Outputs and `lvl` update on the next edge.
- **Request posting.** `o_vol` leaves FFFF 1 cycle after `pend` is set, provided the FSM is in IDLE and `o_pause`=0.
- **Ack latency.** `o_vol` returns to FFFF 3 cycles after an `i_ack` rising edge: 2 synchroniser cycles plus 1.
- **Reset mid-request.** Asynchronous return to the reset values; no partial word is ever driven.
- **`o_level`** is registered and always equals `lvl`.

## Configuration
- **`MP3_CTRL_AUTOREPEAT_EN` defined.** While the up or down debounced level stays high, an additional press event is generated every `REPEAT_CYC` cycles after the initial edge. Repeat events follow the same saturation rules.
- **`MP3_CTRL_AUTOREPEAT_EN` undefined.** One event per press only; the repeat counter is not synthesised and `REPEAT_CYC` is ignored.

## Test plan
All scenarios run with `DEBOUNCE_CYC`=4 and `VOL_STEP`=8'h10 in the bench.
- **Reset.** Release reset → `o_vol`=16'h2020 within 2 cycles; pulse `i_ack` → `o_vol`=16'hFFFF 3 cycles later.
- **Bounce rejection.** Drive `i_btn_down` toggling every 2 cycles for 20 cycles → no event, `o_level` stays 8'h20. Then hold it high → `o_level`=8'h30 and `o_vol`=16'h3030.
- **Saturation.** 3 up presses from 8'h20 → `o_level`=8'h00 and final request 16'h0000. 20 down presses → `o_level`=8'hFE and request 16'hFEFE, never FFFF.
- **Pause deferral.** Press pause then down → `o_pause`=1 and `o_vol` stays FFFF. Hold `i_ack` high → no clear. Press pause → `o_vol`=16'h3030.
- **Song change.** Press next → `o_song_select` toggles and `o_vol` re-posts the current level. Simultaneous up and down → `o_level` unchanged.
- **Auto-repeat.** With `MP3_CTRL_AUTOREPEAT_EN` defined and `REPEAT_CYC`=50, hold up for 160 cycles → 4 decrements. Without the macro → 1 decrement.
